// File: rtl/grf_wb_pkg.sv
// Shared widths and the queued write-back entry type for the GRF write-back arbiter.
package grf_wb_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] pc;
  } wb_entry_t;

endpackage

// File: rtl/grf_wb_fifo.sv
// Dual-push, single-pop circular buffer; push_a lands before push_m in the same cycle.
module grf_wb_fifo #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = grf_wb_pkg::ADDR_W,
  parameter int DATA_W = grf_wb_pkg::DATA_W,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_push_a,
  input  logic [ADDR_W-1:0]              i_a_addr,
  input  logic [DATA_W-1:0]              i_a_data,
  input  logic [DATA_W-1:0]              i_a_pc,
  input  logic                           i_push_m,
  input  logic [ADDR_W-1:0]              i_m_addr,
  input  logic [DATA_W-1:0]              i_m_data,
  input  logic [DATA_W-1:0]              i_m_pc,
  input  logic                           i_pop,
  output logic [CNT_W-1:0]               o_count,
  output logic [ADDR_W-1:0]              o_head_addr,
  output logic [DATA_W-1:0]              o_head_data,
  output logic [DATA_W-1:0]              o_head_pc,
  output logic [DEPTH-1:0]               o_ent_valid,
  output logic [DEPTH-1:0][ADDR_W-1:0]   o_ent_addr
);
  import grf_wb_pkg::*;

  logic [ADDR_W-1:0] r_addr_mem [DEPTH];
  logic [DATA_W-1:0] r_data_mem [DEPTH];
  logic [DATA_W-1:0] r_pc_mem   [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [PTR_W-1:0]  w_wr_ptr_m;

  // The MDU entry goes one slot further when the pipeline also pushes this cycle.
  assign w_wr_ptr_m = r_wr_ptr + PTR_W'(i_push_a);

  always_ff @(posedge clk) begin
    if (i_push_a) begin
      r_addr_mem[r_wr_ptr] <= i_a_addr;
      r_data_mem[r_wr_ptr] <= i_a_data;
      r_pc_mem[r_wr_ptr]   <= i_a_pc;
    end
    if (i_push_m) begin
      r_addr_mem[w_wr_ptr_m] <= i_m_addr;
      r_data_mem[w_wr_ptr_m] <= i_m_data;
      r_pc_mem[w_wr_ptr_m]   <= i_m_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + PTR_W'(i_push_a) + PTR_W'(i_push_m);
      r_rd_ptr <= r_rd_ptr + PTR_W'(i_pop);
      r_count  <= r_count + CNT_W'(i_push_a) + CNT_W'(i_push_m) - CNT_W'(i_pop);
    end
  end

  assign o_count     = r_count;
  assign o_head_addr = r_addr_mem[r_rd_ptr];
  assign o_head_data = r_data_mem[r_rd_ptr];
  assign o_head_pc   = r_pc_mem[r_rd_ptr];

  // A slot is live when its distance from the read pointer is below the occupancy.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ent
    logic [PTR_W-1:0] w_off;
    assign w_off           = PTR_W'(gi) - r_rd_ptr;
    assign o_ent_valid[gi] = ({1'b0, w_off} < r_count);
    assign o_ent_addr[gi]  = r_addr_mem[gi];
  end

endmodule

// File: rtl/grf_wb_arbiter.sv
// GRF write-back arbiter: pipeline/MDU handshakes into a FIFO, one registered write per cycle.
// Define GRF_WB_TRACE_EN to print the grader trace line for every write.
module grf_wb_arbiter #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = grf_wb_pkg::ADDR_W,
  parameter int DATA_W = grf_wb_pkg::DATA_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_a_valid,
  output logic                     o_a_ready,
  input  logic [ADDR_W-1:0]        i_a_addr,
  input  logic [DATA_W-1:0]        i_a_data,
  input  logic [DATA_W-1:0]        i_a_pc,
  input  logic                     i_m_valid,
  output logic                     o_m_ready,
  input  logic [ADDR_W-1:0]        i_m_addr,
  input  logic [DATA_W-1:0]        i_m_data,
  input  logic [DATA_W-1:0]        i_m_pc,
  output logic                     o_we,
  output logic [ADDR_W-1:0]        o_a3,
  output logic [DATA_W-1:0]        o_wd,
  output logic [DATA_W-1:0]        o_wpc,
  output logic [(1<<ADDR_W)-1:0]   o_busy
);
  import grf_wb_pkg::*;

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [CNT_W-1:0]             w_count;
  logic [CNT_W-1:0]             w_free;
  logic                         w_a_ready;
  logic                         w_m_ready;
  logic                         w_push_a;
  logic                         w_push_m;
  logic                         w_pop;
  logic [ADDR_W-1:0]            w_head_addr;
  logic [DATA_W-1:0]            w_head_data;
  logic [DATA_W-1:0]            w_head_pc;
  logic [DEPTH-1:0]             w_ent_valid;
  logic [DEPTH-1:0][ADDR_W-1:0] w_ent_addr;
  logic [(1<<ADDR_W)-1:0]       w_busy;
  logic                         r_we;
  logic [ADDR_W-1:0]            r_a3;
  logic [DATA_W-1:0]            r_wd;
  logic [DATA_W-1:0]            r_wpc;

  // Free space ignores a same-cycle pop; the pipeline reserves a slot ahead of the MDU.
  assign w_free    = CNT_W'(DEPTH) - w_count;
  assign w_a_ready = rst_n & (w_free >= CNT_W'(1));
  assign w_m_ready = rst_n & (i_a_valid ? (w_free >= CNT_W'(2)) : (w_free >= CNT_W'(1)));
  assign w_push_a  = i_a_valid & w_a_ready & (i_a_addr != '0);
  assign w_push_m  = i_m_valid & w_m_ready & (i_m_addr != '0);
  assign w_pop     = (w_count != '0);

  grf_wb_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push_a    (w_push_a),
    .i_a_addr    (i_a_addr),
    .i_a_data    (i_a_data),
    .i_a_pc      (i_a_pc),
    .i_push_m    (w_push_m),
    .i_m_addr    (i_m_addr),
    .i_m_data    (i_m_data),
    .i_m_pc      (i_m_pc),
    .i_pop       (w_pop),
    .o_count     (w_count),
    .o_head_addr (w_head_addr),
    .o_head_data (w_head_data),
    .o_head_pc   (w_head_pc),
    .o_ent_valid (w_ent_valid),
    .o_ent_addr  (w_ent_addr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we  <= 1'b0;
      r_a3  <= '0;
      r_wd  <= '0;
      r_wpc <= '0;
    end else if (w_pop) begin
      r_we  <= 1'b1;
      r_a3  <= w_head_addr;
      r_wd  <= w_head_data;
      r_wpc <= w_head_pc;
    end else begin
      r_we  <= 1'b0;
    end
  end

  // The output register is excluded: the GRF forwards wd while we is high.
  always_comb begin
    w_busy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_ent_valid[i]) w_busy[w_ent_addr[i]] = 1'b1;
    end
  end

`ifdef GRF_WB_TRACE_EN
  always @(posedge clk) begin
    if (r_we) $display("%d@%h: $%d <= %h", $time, r_wpc, r_a3, r_wd);
  end
`else
`endif

  assign o_a_ready = w_a_ready;
  assign o_m_ready = w_m_ready;
  assign o_we      = r_we;
  assign o_a3      = r_a3;
  assign o_wd      = r_wd;
  assign o_wpc     = r_wpc;
  assign o_busy    = w_busy;

endmodule

// File: tb/tb_grf_wb_arbiter.sv
// Directed bench for grf_wb_arbiter: single write, dual enqueue, fill, register 0, async reset.
module tb_grf_wb_arbiter;
  import grf_wb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_valid, m_valid;
  logic        a_ready, m_ready;
  logic [4:0]  a_addr, m_addr;
  logic [31:0] a_data, m_data, a_pc, m_pc;
  logic        we;
  logic [4:0]  a3;
  logic [31:0] wd, wpc;
  logic [31:0] busy;

  int n_vec = 0;
  int n_err = 0;
  wb_entry_t mq[$];

  always #5 clk = ~clk;

  grf_wb_arbiter #(.DEPTH(4), .ADDR_W(5), .DATA_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_a_valid (a_valid),
    .o_a_ready (a_ready),
    .i_a_addr  (a_addr),
    .i_a_data  (a_data),
    .i_a_pc    (a_pc),
    .i_m_valid (m_valid),
    .o_m_ready (m_ready),
    .i_m_addr  (m_addr),
    .i_m_data  (m_data),
    .i_m_pc    (m_pc),
    .o_we      (we),
    .o_a3      (a3),
    .o_wd      (wd),
    .o_wpc     (wpc),
    .o_busy    (busy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard step: pop head into the expected output register, then append accepted entries.
  task automatic model_edge(input bit acc_a, input bit acc_m);
    wb_entry_t ea, em, h;
    logic [31:0] bz;
    ea = {a_addr, a_data, a_pc};
    em = {m_addr, m_data, m_pc};
    tick();
    if (mq.size() > 0) begin
      h = mq.pop_front();
      chk("fill_we", we, 1);
      chk("fill_a3", a3, h.addr);
      chk("fill_wd", wd, h.data);
      chk("fill_wpc", wpc, h.pc);
      $display("wb $%0d <= %h pc %h", a3, wd, wpc);
    end else begin
      chk("fill_we_idle", we, 0);
    end
    if (acc_a && ea.addr != 5'd0) mq.push_back(ea);
    if (acc_m && em.addr != 5'd0) mq.push_back(em);
    bz = '0;
    foreach (mq[i]) bz[mq[i].addr] = 1'b1;
    chk("fill_busy", busy, bz);
  endtask

  initial begin
    int ia, im;
    bit er_m;
    rst_n = 1'b0;
    a_valid = 0; m_valid = 0;
    a_addr = 0; a_data = 0; a_pc = 0;
    m_addr = 0; m_data = 0; m_pc = 0;

    // Reset state
    repeat (2) tick();
    chk("rst_we", we, 0);
    chk("rst_a3", a3, 0);
    chk("rst_wd", wd, 0);
    chk("rst_wpc", wpc, 0);
    chk("rst_busy", busy, 0);
    chk("rst_a_ready", a_ready, 0);
    chk("rst_m_ready", m_ready, 0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_a_ready", a_ready, 1);
    chk("post_rst_m_ready", m_ready, 1);

    // Single write: addr 5 visible on we two edges after issue
    a_valid = 1; a_addr = 5; a_data = 32'h1234; a_pc = 32'h3000;
    chk("single_a_ready", a_ready, 1);
    tick();
    a_valid = 0;
    chk("single_we_n", we, 0);
    chk("single_busy_n", busy, 32'h20);
    tick();
    chk("single_we", we, 1);
    chk("single_a3", a3, 5);
    chk("single_wd", wd, 32'h1234);
    chk("single_wpc", wpc, 32'h3000);
    chk("single_busy_n1", busy, 0);
    $display("wb $%0d <= %h pc %h", a3, wd, wpc);
    tick();
    chk("single_we_drop", we, 0);
    chk("single_a3_hold", a3, 5);

    // Simultaneous producers: pipeline first
    a_valid = 1; a_addr = 3; a_data = 32'hAAAA; a_pc = 32'h3004;
    m_valid = 1; m_addr = 4; m_data = 32'hBBBB; m_pc = 32'h2ff0;
    chk("dual_a_ready", a_ready, 1);
    chk("dual_m_ready", m_ready, 1);
    tick();
    a_valid = 0; m_valid = 0;
    chk("dual_busy0", busy, 32'h18);
    chk("dual_we0", we, 0);
    tick();
    chk("dual_we1", we, 1);
    chk("dual_a3_1", a3, 3);
    chk("dual_wd_1", wd, 32'hAAAA);
    chk("dual_busy1", busy, 32'h10);
    $display("wb $%0d <= %h pc %h", a3, wd, wpc);
    tick();
    chk("dual_we2", we, 1);
    chk("dual_a3_2", a3, 4);
    chk("dual_wd_2", wd, 32'hBBBB);
    chk("dual_wpc_2", wpc, 32'h2ff0);
    chk("dual_busy2", busy, 0);
    $display("wb $%0d <= %h pc %h", a3, wd, wpc);
    tick();
    chk("dual_we3", we, 0);

    // Register 0 is accepted but never stored
    a_valid = 1; a_addr = 0; a_data = 32'hDEAD; a_pc = 32'h3008;
    chk("r0_a_ready", a_ready, 1);
    tick();
    a_valid = 0;
    chk("r0_busy", busy, 0);
    chk("r0_we0", we, 0);
    tick();
    chk("r0_we1", we, 0);
    tick();
    chk("r0_we2", we, 0);

    // Fill: both producers held; from count 3 onward only the pipeline fits
    a_valid = 1; m_valid = 1; ia = 0; im = 0;
    for (int k = 0; k < 8; k++) begin
      a_addr = 5'(8 + ia);  a_data = 32'hA000 + ia; a_pc = 32'h4000 + 4 * ia;
      m_addr = 5'(20 + im); m_data = 32'hB000 + im; m_pc = 32'h5000 + 4 * im;
      er_m = (k < 2);
      chk("fill_a_ready", a_ready, 1);
      chk("fill_m_ready", m_ready, er_m);
      model_edge(1'b1, er_m);
      ia++;
      if (er_m) im++;
    end
    a_valid = 0; m_valid = 0;
    repeat (5) model_edge(1'b0, 1'b0);

    // Reset mid-burst with three entries queued
    a_valid = 1; a_addr = 1; a_data = 32'h11; a_pc = 32'h6000;
    m_valid = 1; m_addr = 2; m_data = 32'h22; m_pc = 32'h7000;
    tick();
    a_addr = 6; a_data = 32'h66; a_pc = 32'h6004;
    m_addr = 7; m_data = 32'h77; m_pc = 32'h7004;
    chk("burst_m_ready", m_ready, 1);
    tick();
    a_valid = 0; m_valid = 0;
    chk("burst_we", we, 1);
    chk("burst_a3", a3, 1);
    chk("burst_busy", busy, 32'hC4);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_we", we, 0);
    chk("midrst_a3", a3, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_a_ready", a_ready, 0);
    chk("midrst_m_ready", m_ready, 0);
    #2 rst_n = 1'b1;
    #1;
    chk("rel_a_ready", a_ready, 1);
    chk("rel_m_ready", m_ready, 1);
    chk("rel_busy", busy, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rel_no_stale_we", we, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
